inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 clk  in  1  single clock; all state on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 clear  in  1  synchronous pipeline flush plus address and error-counter reload.
REQ-004 base_addr  in  32  address loaded by reset/clear; bits[1:0] ignored (forced 0).
REQ-005 in_valid / in_ready  in / out  1 / 1  request handshake; a transfer occurs when both are high.
REQ-006 in_op  in  5  operation code:
- 0-9: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND
- 10-18: ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI
- 19-20: LW SW
- 21-26: BEQ BNE BLT BGE BLTU BGEU
- 27-30: LUI AUIPC JAL JALR
- 31: illegal
REQ-007 in_rd, in_rs1, in_rs2  in  5 each  register fields.
REQ-008 in_imm  in  32  signed immediate, byte offset for branch/jump, full 32-bit value for LUI/AUIPC.
REQ-009 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-010 out_inst  out  32  encoded RV32I instruction word.
REQ-011 out_addr  out  32  instruction-memory byte address of out_inst.
REQ-012 out_err  out  1  current out_inst is a substituted NOP because of an error.
REQ-013 err_cnt  out  8  saturating count of errored instructions delivered.

Function
REQ-014 The block SHALL be a 2-stage pipeline (S1 registers request, S2 registers encoded word); latency accept->out_valid = 2 cycles.
REQ-015 A stage SHALL load when it is empty or its contents leave the same cycle; in_ready = !S1_valid || S1 advancing (combinational from out_ready permitted).
REQ-016 No request SHALL be dropped or duplicated; out_* SHALL hold stable while out_valid && !out_ready.
REQ-017 Encoding SHALL follow RV32I base formats:
- R: funct7=0x20 for SUB/SRA, else 0.
- I: SRAI funct7=0x20, shift amount in imm[4:0].
- S, B, U, J, JALR: standard field placement.
- Unused fields are zero; rd/rs2 are ignored where the format lacks them.
REQ-018 Errors SHALL cause out_inst=0x00000013 (NOP) with out_err=1:
- in_op=31.
- I/S/JALR imm outside [-2048,2047].
- Shift imm outside [0,31].
- B imm odd or outside [-4096,4094].
- JAL imm odd or outside [-1048576,1048574].
- LUI/AUIPC imm[11:0]!=0.
REQ-019 out_addr SHALL advance by 4 on each out_valid&&out_ready; 0xFFFFFFFC wraps to 0x00000000.
REQ-020 err_cnt SHALL increment on each delivered errored word and saturate at 255.
REQ-021 clear SHALL invalidate S1/S2, load out_addr=base_addr, zero err_cnt, and force in_ready=0 that cycle; clear overrides any simultaneous handshake.
REQ-022 Encoding SHALL be combinational between S1 and S2; no cycle depends on in_op.

Reset
REQ-023 While rst_n=0: S1/S2 invalid, out_valid=0, in_ready=0, out_inst=0, out_err=0, err_cnt=0, out_addr=base_addr.
REQ-024 Reset assertion mid-operation SHALL discard in-flight words; in_ready SHALL rise the first cycle after deassertion.

Structure
REQ-025 Package rv_enc_pkg SHALL hold:
- op enum (REQ-006).
- 7-bit opcode constants.
- funct3/funct7 constants.
- NOP constant 0x00000013.
- Immediate range limits.
REQ-026 Sub-module inst_enc_core SHALL hold the combinational encoder: op, rd, rs1, rs2, imm -> inst, err.

Verification
REQ-027 ADD rd=3 rs1=1 rs2=2 -> out_inst 0x002081B3, out_addr=base_addr, 2 cycles after accept.
REQ-028 Back-to-back ADDI x1,x0,5 / SRAI x1,x1,3 / BEQ x1,x2,+8 / LUI x5,0x12345000, out_ready=1:
- Outputs 0x00500093, 0x4030D093, 0x00208463, 0x123452B7 on consecutive cycles.
- Addresses +0, +4, +8, +12.
REQ-029 JAL imm=3, then ADDI imm=4096 -> two NOPs 0x00000013, out_err=1, err_cnt=2.
REQ-030 out_ready=0 for 5 cycles with in_valid=1 -> in_ready low after 2 accepts; out_inst stable; no loss/duplication after release.
REQ-031 base_addr=0xFFFFFFF8, clear, 3 words -> out_addr 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-032 clear and rst_n pulses with 2 words in flight -> out_valid=0 next cycle, err_cnt=0, out_addr=base_addr.

Source files
------------

// File: rtl/rv_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Op codes, opcode/funct fields, the NOP word and immediate range limits live here.
package rv_enc_pkg;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LW, OP_SW,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_ILLEGAL
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } req_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_ZERO = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int SHAMT_MAX = 31;
    localparam int BIMM_MIN  = -4096;
    localparam int BIMM_MAX  = 4094;
    localparam int JIMM_MIN  = -1048576;
    localparam int JIMM_MAX  = 1048574;

    function automatic logic [2:0] funct3_of(input op_e op);
        case (op)
            OP_SLL, OP_SLLI:                return F3_SLL;
            OP_SLT, OP_SLTI, OP_LW, OP_SW:  return F3_SLT;
            OP_SLTU, OP_SLTIU:              return F3_SLTU;
            OP_XOR, OP_XORI:                return F3_XOR;
            OP_SRL, OP_SRA, OP_SRLI, OP_SRAI: return F3_SR;
            OP_OR, OP_ORI:                  return F3_OR;
            OP_AND, OP_ANDI:                return F3_AND;
            OP_BNE:                         return F3_BNE;
            OP_BLT:                         return F3_BLT;
            OP_BGE:                         return F3_BGE;
            OP_BLTU:                        return F3_BLTU;
            OP_BGEU:                        return F3_BGEU;
            default:                        return F3_ADD;
        endcase
    endfunction

    function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/inst_enc_core.sv
// Combinational RV32I encoder: one request in, one instruction word out.
// Any out-of-range immediate or illegal op collapses the word to a NOP with err set.
module inst_enc_core
    import rv_enc_pkg::*;
(
    input  op_e         op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        err
);

    logic [31:0] raw;
    logic        bad;
    logic [2:0]  f3;

    assign f3 = funct3_of(op);

    always_comb begin
        raw = NOP_INST;
        bad = 1'b0;
        case (op)
            OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND:
                raw = {F7_ZERO, rs2, rs1, f3, rd, OPC_OP};
            OP_SUB, OP_SRA:
                raw = {F7_ALT, rs2, rs1, f3, rd, OPC_OP};
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI: begin
                bad = !in_range(imm, IMM12_MIN, IMM12_MAX);
                raw = {imm[11:0], rs1, f3, rd, OPC_OPIMM};
            end
            OP_SLLI, OP_SRLI: begin
                bad = !in_range(imm, 0, SHAMT_MAX);
                raw = {F7_ZERO, imm[4:0], rs1, f3, rd, OPC_OPIMM};
            end
            OP_SRAI: begin
                bad = !in_range(imm, 0, SHAMT_MAX);
                raw = {F7_ALT, imm[4:0], rs1, f3, rd, OPC_OPIMM};
            end
            OP_LW: begin
                bad = !in_range(imm, IMM12_MIN, IMM12_MAX);
                raw = {imm[11:0], rs1, F3_WORD, rd, OPC_LOAD};
            end
            OP_SW: begin
                bad = !in_range(imm, IMM12_MIN, IMM12_MAX);
                raw = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPC_STORE};
            end
            // Branch and jump offsets are byte offsets; bit 0 must be clear.
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                bad = imm[0] || !in_range(imm, BIMM_MIN, BIMM_MAX);
                raw = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
            end
            OP_LUI: begin
                bad = |imm[11:0];
                raw = {imm[31:12], rd, OPC_LUI};
            end
            OP_AUIPC: begin
                bad = |imm[11:0];
                raw = {imm[31:12], rd, OPC_AUIPC};
            end
            OP_JAL: begin
                bad = imm[0] || !in_range(imm, JIMM_MIN, JIMM_MAX);
                raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            end
            OP_JALR: begin
                bad = !in_range(imm, IMM12_MIN, IMM12_MAX);
                raw = {imm[11:0], rs1, F3_ADD, rd, OPC_JALR};
            end
            default:
                bad = 1'b1;
        endcase
    end

    assign inst = bad ? NOP_INST : raw;
    assign err  = bad;

endmodule

// File: rtl/inst_encoder.sv
// Two-stage RV32I instruction encoder: S1 holds the request, S2 the encoded word.
// out_addr is the instruction-memory byte address of the word currently presented.
module inst_encoder
    import rv_enc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [7:0]  err_cnt
);

    req_t        req_in;
    req_t        s1_req;
    logic        s1_valid;
    logic        s2_valid;
    logic        s2_free;
    logic        s1_adv;
    logic        accept;
    logic        deliver;
    logic [31:0] enc_inst;
    logic        enc_err;
    logic [31:0] base_word;
    logic [31:0] addr_q;
    logic        addr_live;
    logic [31:0] cur_addr;

    assign req_in    = '{op: op_e'(in_op), rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
    assign s2_free   = !s2_valid || out_ready;
    assign s1_adv    = s1_valid && s2_free;
    assign in_ready  = rst_n && !clear && (!s1_valid || s1_adv);
    assign accept    = in_valid && in_ready;
    assign deliver   = s2_valid && out_ready && !clear;
    assign out_valid = s2_valid;
    assign base_word = base_addr & 32'hFFFF_FFFC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_req   <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_req   <= req_in;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    inst_enc_core u_core (
        .op   (s1_req.op),
        .rd   (s1_req.rd),
        .rs1  (s1_req.rs1),
        .rs2  (s1_req.rs2),
        .imm  (s1_req.imm),
        .inst (enc_inst),
        .err  (enc_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_inst <= '0;
            out_err  <= 1'b0;
        end else if (clear) begin
            s2_valid <= 1'b0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_inst <= enc_inst;
                out_err  <= enc_err;
            end
        end
    end

    // Until the first edge after reset the address follows base_addr directly,
    // since an asynchronous reset cannot load a non-constant value.
    assign cur_addr = addr_live ? addr_q : base_word;
    assign out_addr = cur_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            addr_live <= 1'b0;
        end else if (clear) begin
            addr_q    <= base_word;
            addr_live <= 1'b1;
        end else begin
            addr_live <= 1'b1;
            addr_q    <= deliver ? cur_addr + 32'd4 : cur_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clear) begin
            err_cnt <= '0;
        end else if (deliver && out_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: the driver queues expected words from a
// field-level RV32I reference, and a negedge monitor pops them on every delivery.
module tb_inst_encoder;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_cnt;

    inst_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    typedef struct {
        logic [31:0] inst;
        logic        err;
        bit          fix_addr;
        logic [31:0] addr;
        int          accept_cycle;
        bit          want_lat2;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle_cnt = 0;
    int          ready_mode = 0;
    logic [31:0] addr_model;
    int          err_model;
    bit          flush_pending = 0;
    bit          hold_pending = 0;
    logic [31:0] held_inst;
    logic [31:0] held_addr;
    logic        held_err;

    int r_f3 [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int i_f3 [9]  = '{0, 2, 3, 4, 6, 7, 1, 5, 5};
    int b_f3 [6]  = '{0, 1, 4, 5, 6, 7};
    logic [31:0] edge_imms [20] = '{
        32'd0, 32'd31, 32'd32, 32'd2047, 32'd2048, 32'hFFFF_F800, 32'hFFFF_F7FF,
        32'd4094, 32'd4096, 32'hFFFF_F000, 32'hFFFF_EFFE, 32'h000F_FFFE, 32'h0010_0000,
        32'hFFF0_0000, 32'hFFEF_FFFE, 32'hFFFF_FFFF, 32'd3, 32'h1234_5000, 32'd4095,
        32'h000F_FFFF
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached with %0d words pending", exp_q.size());
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference: bit 32 = error flag, bits 31:0 = word, built from the RV32I format tables.
    function automatic logic [32:0] refEncode(input int op, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [31:0] imm);
        int          v;
        logic [2:0]  f;
        logic [31:0] w;
        bit          bad;
        v   = $signed(imm);
        w   = 32'h13;
        bad = 0;
        f   = 3'd0;
        if (op < 10) begin
            f = 3'(r_f3[op]);
            w = {((op == 1) || (op == 7)) ? 7'h20 : 7'h00, rs2, rs1, f, rd, 7'h33};
        end else if (op < 16) begin
            f   = 3'(i_f3[op - 10]);
            bad = (v < -2048) || (v > 2047);
            w   = {imm[11:0], rs1, f, rd, 7'h13};
        end else if (op < 19) begin
            f   = 3'(i_f3[op - 10]);
            bad = (v < 0) || (v > 31);
            w   = {(op == 18) ? 7'h20 : 7'h00, imm[4:0], rs1, f, rd, 7'h13};
        end else if (op == 19) begin
            bad = (v < -2048) || (v > 2047);
            w   = {imm[11:0], rs1, 3'd2, rd, 7'h03};
        end else if (op == 20) begin
            bad = (v < -2048) || (v > 2047);
            w   = {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
        end else if (op < 27) begin
            f   = 3'(b_f3[op - 21]);
            bad = imm[0] || (v < -4096) || (v > 4094);
            w   = {imm[12], imm[10:5], rs2, rs1, f, imm[4:1], imm[11], 7'h63};
        end else if (op < 29) begin
            bad = (imm[11:0] != 12'd0);
            w   = {imm[31:12], rd, (op == 27) ? 7'h37 : 7'h17};
        end else if (op == 29) begin
            bad = imm[0] || (v < -1048576) || (v > 1048574);
            w   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
        end else if (op == 30) begin
            bad = (v < -2048) || (v > 2047);
            w   = {imm[11:0], rs1, 3'd0, rd, 7'h67};
        end else begin
            bad = 1;
        end
        if (bad) w = 32'h13;
        return {bad, w};
    endfunction

    function automatic logic [31:0] pickImm();
        int          sel;
        logic [31:0] tmp;
        sel = $urandom_range(0, 5);
        tmp = $urandom;
        case (sel)
            0:       return tmp;
            1:       return 32'($urandom_range(0, 63)) - 32'd32;
            2:       return edge_imms[$urandom_range(0, 19)];
            3:       return {tmp[19:0], 12'h000};
            4:       return (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFF_FFFE;
            default: return 32'($urandom_range(0, 2097151)) - 32'd1048576;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    endtask

    // Offers one request for one cycle; queues its expected result if taken.
    task automatic applyStimulus(input int op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [31:0] imm,
                                 input bit use_fix, input logic [31:0] fix_inst,
                                 input logic fix_err, input bit fix_addr,
                                 input logic [31:0] addr, input bit lat2,
                                 output bit accepted);
        exp_t        e;
        logic [32:0] m;
        in_valid = 1'b1;
        in_op    = 5'(op);
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        @(negedge clk);
        accepted = in_ready;
        if (accepted) begin
            m              = refEncode(op, rd, rs1, rs2, imm);
            e.inst         = use_fix ? fix_inst : m[31:0];
            e.err          = use_fix ? fix_err : m[32];
            e.fix_addr     = fix_addr;
            e.addr         = addr;
            e.accept_cycle = cycle_cnt;
            e.want_lat2    = lat2;
            exp_q.push_back(e);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic sendOne(input int op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm,
                           input bit use_fix, input logic [31:0] fix_inst,
                           input logic fix_err, input bit fix_addr,
                           input logic [31:0] addr, input bit lat2);
        bit acc;
        acc = 0;
        for (int t = 0; t < 50 && !acc; t++)
            applyStimulus(op, rd, rs1, rs2, imm, use_fix, fix_inst, fix_err,
                          fix_addr, addr, lat2, acc);
        checkOutput("request accepted", {31'b0, acc}, 32'd1);
    endtask

    task automatic sendRandom();
        sendOne($urandom_range(0, 31), 5'($urandom), 5'($urandom), 5'($urandom),
                pickImm(), 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        ready_mode = 0;
        out_ready  = 1'b1;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++)
            @(negedge clk);
        checkOutput("drain pending words", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    task automatic doClear(input logic [31:0] b);
        base_addr = b;
        clear     = 1'b1;
        in_valid  = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    task automatic checkResetValues();
        checkOutput("reset in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset out_inst", out_inst, 32'd0);
        checkOutput("reset out_err", {31'b0, out_err}, 32'd0);
        checkOutput("reset err_cnt", {24'b0, err_cnt}, 32'd0);
        checkOutput("reset out_addr", out_addr, base_addr & 32'hFFFF_FFFC);
    endtask

    // Monitor: flushes on clear/reset, checks holds while stalled, pops on delivery.
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (!rst_n || clear) begin
            exp_q.delete();
            addr_model    = base_addr & 32'hFFFF_FFFC;
            err_model     = 0;
            flush_pending = 1;
            hold_pending  = 0;
        end else begin
            if (flush_pending) begin
                checkOutput("flush out_valid", {31'b0, out_valid}, 32'd0);
                checkOutput("flush err_cnt", {24'b0, err_cnt}, 32'd0);
                checkOutput("flush out_addr", out_addr, addr_model);
                flush_pending = 0;
            end
            if (hold_pending) begin
                checkOutput("stall out_valid held", {31'b0, out_valid}, 32'd1);
                checkOutput("stall out_inst held", out_inst, held_inst);
                checkOutput("stall out_addr held", out_addr, held_addr);
                checkOutput("stall out_err held", {31'b0, out_err}, {31'b0, held_err});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious output, queue depth", 32'(exp_q.size()), 32'd1);
                end else begin
                    e   = exp_q.pop_front();
                    lat = cycle_cnt - e.accept_cycle;
                    checkOutput("out_inst", out_inst, e.inst);
                    checkOutput("out_err", {31'b0, out_err}, {31'b0, e.err});
                    checkOutput("out_addr", out_addr, e.fix_addr ? e.addr : addr_model);
                    checkOutput("err_cnt", {24'b0, err_cnt}, 32'(err_model));
                    if (e.want_lat2)
                        checkOutput("latency", 32'(lat), 32'd2);
                    else
                        checkOutput("latency at least 2", {31'b0, lat >= 2}, 32'd1);
                    addr_model = addr_model + 32'd4;
                    if (e.err && err_model < 255) err_model++;
                end
            end
            hold_pending = out_valid && !out_ready;
            held_inst    = out_inst;
            held_addr    = out_addr;
            held_err     = out_err;
        end
    end

    initial begin
        int acc_count;
        bit acc;
        rst_n     = 1'b0;
        clear     = 1'b0;
        base_addr = 32'h0000_0102;
        in_valid  = 1'b0;
        in_op     = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_imm    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready after reset release", {31'b0, in_ready}, 32'd1);
        tick();

        $display("[TB] single ADD");
        sendOne(0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h0020_81B3, 1'b0, 1, 32'h0000_0100, 1);
        drain();

        $display("[TB] back-to-back sequence");
        doClear(32'h0000_2000);
        sendOne(10, 5'd1, 5'd0, 5'd0, 32'd5, 1, 32'h0050_0093, 1'b0, 1, 32'h0000_2000, 1);
        sendOne(18, 5'd1, 5'd1, 5'd0, 32'd3, 1, 32'h4030_D093, 1'b0, 1, 32'h0000_2004, 1);
        sendOne(21, 5'd0, 5'd1, 5'd2, 32'd8, 1, 32'h0020_8463, 1'b0, 1, 32'h0000_2008, 1);
        sendOne(27, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1, 32'h1234_52B7, 1'b0, 1, 32'h0000_200C, 1);
        drain();

        $display("[TB] error substitution");
        doClear(32'h0000_3000);
        sendOne(29, 5'd1, 5'd0, 5'd0, 32'd3, 1, 32'h0000_0013, 1'b1, 0, 0, 0);
        sendOne(10, 5'd1, 5'd0, 5'd0, 32'd4096, 1, 32'h0000_0013, 1'b1, 0, 0, 0);
        drain();
        checkOutput("err_cnt after two errors", {24'b0, err_cnt}, 32'd2);

        $display("[TB] output stall");
        ready_mode = 2;
        out_ready  = 1'b0;
        acc_count  = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(10, 5'd2, 5'd0, 5'd0, 32'(i + 1), 0, 0, 0, 0, 0, 0, acc);
            acc_count += int'(acc);
        end
        checkOutput("accepts during stall", 32'(acc_count), 32'd2);
        checkOutput("in_ready during stall", {31'b0, in_ready}, 32'd0);
        drain();

        $display("[TB] address wrap");
        doClear(32'hFFFF_FFF8);
        sendOne(0, 5'd4, 5'd5, 5'd6, 32'd0, 0, 0, 0, 1, 32'hFFFF_FFF8, 0);
        sendOne(9, 5'd7, 5'd8, 5'd9, 32'd0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        sendOne(30, 5'd1, 5'd2, 5'd0, 32'hFFFF_F800, 0, 0, 0, 1, 32'h0000_0000, 0);
        drain();

        $display("[TB] clear with words in flight");
        sendOne(11, 5'd1, 5'd2, 5'd0, 32'd7, 0, 0, 0, 0, 0, 0);
        sendOne(31, 5'd1, 5'd2, 5'd0, 32'd0, 0, 0, 0, 0, 0, 0);
        doClear(32'h0000_4000);
        checkOutput("post-clear out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("post-clear err_cnt", {24'b0, err_cnt}, 32'd0);
        checkOutput("post-clear out_addr", out_addr, 32'h0000_4000);

        $display("[TB] reset with words in flight");
        sendOne(31, 5'd1, 5'd2, 5'd0, 32'd0, 0, 0, 0, 0, 0, 0);
        sendOne(2, 5'd1, 5'd2, 5'd3, 32'd0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        checkResetValues();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready after mid-run reset", {31'b0, in_ready}, 32'd1);
        tick();

        $display("[TB] randomized traffic");
        doClear(32'h0000_1003);
        ready_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) doClear($urandom);
            else if ($urandom_range(0, 3) == 0) tick();
            else sendRandom();
        end
        drain();

        $display("[TB] error counter saturation");
        doClear(32'h0000_5000);
        for (int i = 0; i < 260; i++)
            sendOne(31, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 0, 0, 0, 0, 0, 0);
        drain();
        checkOutput("err_cnt saturated", {24'b0, err_cnt}, 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
